fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin write arbiter sharing one synchronous FIFO between NUM_REQ producers.
//  Each producer offers data on a valid/ready handshake. The arbiter picks one
//  producer and drives the FIFO write port (wr, data_in) in the same cycle,
//  throttled by the FIFO full and count outputs. Sits directly in front of SYNC_FIFO.
// PARAMETERS
//  NUM_REQ      4   number of producers (>=2)
//  DATA_WIDTH   8   data width; equals the FIFO Data_Width
//  FIFO_DEPTH   16  FIFO depth; sets the fifo_count width
//  BURST_LEN    4   maximum consecutive beats per grant (ARB_BURST_EN only; >=1)
// PORTS
//  clk          in   1                      clock, rising edge
//  rst_n        in   1                      asynchronous, active-low reset
//  req_valid    in   NUM_REQ                per-producer data valid
//  req_data     in   NUM_REQ*DATA_WIDTH     producer i occupies bits [i*DW +: DW]
//  req_ready    out  NUM_REQ                one-hot or zero; beat accepted when valid&ready
//  fifo_full    in   1                      FIFO full flag
//  fifo_count   in   $clog2(FIFO_DEPTH)+1   FIFO occupancy
//  fifo_wr      out  1                      FIFO write strobe
//  fifo_data    out  DATA_WIDTH             FIFO write data
//  grant_id     out  $clog2(NUM_REQ)        index of the current grantee, valid when fifo_wr=1
// BEHAVIOUR
//  - Clock and reset: one clock (clk). Reset (rst_n) is asynchronous and active-low.
//    On reset: rr_ptr=0, state=IDLE, beat_cnt=0.
//    While rst_n=0: fifo_wr=0, req_ready=0, grant_id=0, fifo_data=0.
//  - Latency: zero. req_ready, fifo_wr and fifo_data are combinational from the
//    registered state and the current inputs. The accepted beat reaches the FIFO
//    in the same cycle.
//  - Selection: the first asserted req_valid, searching circularly from rr_ptr.
//  - Stall: no grant while fifo_full=1. In that case req_ready=0 and fifo_wr=0.
//  - Transfer: fifo_wr = req_valid[g] & req_ready[g]. fifo_data = req_data[g].
//    At most one beat per cycle.
//  - Pointer update: after each accepted beat, rr_ptr <= g+1, wrapping
//    NUM_REQ-1 -> 0. No update when there is no transfer.
//  - Valid rule: a producer must hold valid and data stable until ready.
//    The arbiter does not require this for correctness, only for fairness.
//  - Idle: if no req_valid is asserted, all outputs are 0 and the state holds.
//  - Reset mid-burst: returns immediately to the reset values. No partial write
//    is issued, because fifo_wr is gated low.
// CONFIGURATION
//  Macro ARB_BURST_EN.
//  Defined: FSM with states IDLE and BURST.
//   - IDLE -> BURST on an accepted beat from g. Set lock_id=g and beat_cnt=1.
//   - In BURST, only lock_id may receive ready.
//   - BURST -> IDLE when any of these holds; rr_ptr <= lock_id+1 on exit:
//       - beat_cnt reaches BURST_LEN;
//       - req_valid[lock_id]=0;
//       - fifo_count >= FIFO_DEPTH-1 on an accepted beat (the FIFO becomes full).
//   - While fifo_full=1 in BURST: hold the state, stall, do not count.
//  Undefined: no FSM and no beat_cnt. Pure per-beat round-robin as above.
//   fifo_count is unused. BURST_LEN is ignored.
// STRUCTURE
//  Package fifo_arb_pkg:
//   - state enum {IDLE, BURST};
//   - function rr_pick(valid, ptr) -> {found, index}.
//  Sub-module rr_priority_enc: combinational circular first-one finder.
//   Parameterised by NUM_REQ. Used for selection in both configurations.
//  Top level: pointer/FSM registers, output muxing, reset gating.
// TESTING
//  1. Reset: rst_n=0 with all req_valid=1 -> fifo_wr=0, req_ready=0.
//     First cycle after release, grant goes to producer 0.
//  2. All 4 valid, FIFO empty, macro off -> grants 0,1,2,3,0 on consecutive cycles.
//     fifo_data matches each producer's data.
//  3. fifo_full=1 for 3 cycles with valid pending -> no fifo_wr and no pointer move.
//     Grant order resumes unchanged after full drops.
//  4. Only producer 2 valid for 5 cycles -> five beats with grant_id=2.
//     Next arbitration starts from producer 3.
//  5. ARB_BURST_EN, BURST_LEN=4, producers 0 and 1 continuously valid
//     -> 4 beats from 0, then 4 from 1, alternating.
//  6. ARB_BURST_EN, assert rst_n=0 at beat 2 of a burst -> outputs 0 immediately.
//     After release, state=IDLE and grant goes to producer 0.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and the circular first-one search used by the FIFO write arbiter.
// rr_pick works on a fixed MAX_REQ-wide vector so any NUM_REQ up to MAX_REQ can share it.
package fifo_arb_pkg;

  localparam int MAX_REQ = 32;
  localparam int IDX_W   = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] index;
  } rr_pick_t;

  // The lowest offset k from ptr wins, so the result is the first valid bit at or after ptr.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [IDX_W-1:0]   ptr,
                                       input int                 num);
    rr_pick_t res;
    int       idx;
    res = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= num) idx = idx - num;
      if ((k < num) && !res.found && (idx < MAX_REQ) && valid[idx[IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.index = IDX_W'(idx);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshake plus FIFO write port shared by the arbiter and its surroundings.
// master is the arbiter side; slave is the producers/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic [CW-1:0]                 fifo_count;
  logic                          fifo_wr;
  logic [DATA_WIDTH-1:0]         fifo_data;
  logic [GW-1:0]                 grant_id;

  modport master (
    input  req_valid, req_data, fifo_full, fifo_count,
    output req_ready, fifo_wr, fifo_data, grant_id
  );

  modport slave (
    output req_valid, req_data, fifo_full, fifo_count,
    input  req_ready, fifo_wr, fifo_data, grant_id
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_priority_enc.sv
// Combinational circular first-one finder: first set bit of i_valid searching upward from i_ptr.
module rr_priority_enc
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_valid,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic                       o_found,
  output logic [$clog2(NUM_REQ)-1:0] o_index
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [MAX_REQ-1:0] w_valid_pad;
  logic [IDX_W-1:0]   w_ptr_pad;
  rr_pick_t           w_pick;

  assign w_valid_pad = MAX_REQ'(i_valid);
  assign w_ptr_pad   = IDX_W'(i_ptr);
  assign w_pick      = rr_pick(w_valid_pad, w_ptr_pad, NUM_REQ);
  assign o_found     = w_pick.found;
  assign o_index     = IDW'(w_pick.index);

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one synchronous FIFO between NUM_REQ producers.
// Define ARB_BURST_EN to let a grantee keep the FIFO for up to BURST_LEN consecutive beats.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int BURST_LEN  = 4
) (
  input logic               clk,
  input logic               rst_n,
  fifo_wr_arbiter_if.master arb_bus
);

  localparam int GW = $clog2(NUM_REQ);

  if ((NUM_REQ < 2) || (NUM_REQ > MAX_REQ) || (BURST_LEN < 1) || (FIFO_DEPTH < 2)) begin : g_bad_params
    $error("fifo_wr_arbiter: unsupported parameter set");
  end

  logic          w_rr_found;
  logic [GW-1:0] w_rr_idx;
  logic [GW-1:0] r_rr_ptr;
  logic          w_cand_ok;
  logic [GW-1:0] w_cand_idx;
  logic          w_xfer;
  logic [GW-1:0] w_ptr_inc;

  rr_priority_enc #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_enc (
    .i_valid (arb_bus.req_valid),
    .i_ptr   (r_rr_ptr),
    .o_found (w_rr_found),
    .o_index (w_rr_idx)
  );

`ifdef ARB_BURST_EN
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int BCW = $clog2(BURST_LEN + 1);

  arb_state_e     r_state;
  arb_state_e     w_state_nxt;
  logic [GW-1:0]  r_lock_id;
  logic [GW-1:0]  w_lock_nxt;
  logic [BCW-1:0] r_beat_cnt;
  logic [BCW-1:0] w_cnt_nxt;
  logic           w_fifo_filling;

  // A beat accepted at this occupancy leaves the FIFO full, so the burst must end with it.
  assign w_fifo_filling = (arb_bus.fifo_count >= CW'(FIFO_DEPTH - 1));

  always_comb begin
    w_cand_ok  = w_rr_found;
    w_cand_idx = w_rr_idx;
    if (r_state == BURST) begin
      w_cand_ok  = arb_bus.req_valid[r_lock_id];
      w_cand_idx = r_lock_id;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lock_nxt  = r_lock_id;
    w_cnt_nxt   = r_beat_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_xfer && (BURST_LEN > 1) && !w_fifo_filling) begin
          w_state_nxt = BURST;
          w_lock_nxt  = w_cand_idx;
          w_cnt_nxt   = BCW'(1);
        end
      end
      BURST: begin
        if (!arb_bus.fifo_full) begin
          if (!arb_bus.req_valid[r_lock_id]) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else if ((r_beat_cnt == BCW'(BURST_LEN - 1)) || w_fifo_filling) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_beat_cnt + BCW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_lock_id  <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_id  <= w_lock_nxt;
      r_beat_cnt <= w_cnt_nxt;
    end
  end
`else
  assign w_cand_ok  = w_rr_found;
  assign w_cand_idx = w_rr_idx;
`endif

  // rst_n gates the grant directly so nothing reaches the FIFO while reset is held.
  assign w_xfer    = rst_n & ~arb_bus.fifo_full & w_cand_ok;
  assign w_ptr_inc = (w_cand_idx == GW'(NUM_REQ - 1)) ? '0 : w_cand_idx + GW'(1);

  always_comb begin
    arb_bus.req_ready = '0;
    arb_bus.fifo_wr   = 1'b0;
    arb_bus.fifo_data = '0;
    arb_bus.grant_id  = '0;
    if (w_xfer) begin
      arb_bus.req_ready[w_cand_idx] = 1'b1;
      arb_bus.fifo_wr               = 1'b1;
      arb_bus.fifo_data             = arb_bus.req_data[w_cand_idx * DATA_WIDTH +: DATA_WIDTH];
      arb_bus.grant_id              = w_cand_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_xfer) begin
      r_rr_ptr <= w_ptr_inc;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter against a behavioural round-robin model.
// Burst scenarios are compiled in when ARB_BURST_EN is defined.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int BL    = 4;
  localparam int GW    = $clog2(N);
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [N-1:0]  ready;
    logic          wr;
    logic [GW-1:0] id;
    logic [DW-1:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  int   m_ptr;
  bit   m_burst;
  int   m_lock;
  int   m_cnt;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .BURST_LEN  (BL)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .arb_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic m_reset();
    m_ptr   = 0;
    m_burst = 0;
    m_lock  = 0;
    m_cnt   = 0;
  endtask

  // Expected outputs from the spec's rules for the inputs currently driven.
  function automatic exp_t model_eval();
    exp_t e;
    int   g;
    bit   ok;
    e  = '0;
    g  = 0;
    ok = 0;
    if (rst_n && !bus.fifo_full) begin
      if (m_burst) begin
        g  = m_lock;
        ok = bus.req_valid[m_lock];
      end else begin
        for (int k = N - 1; k >= 0; k--) begin
          if (bus.req_valid[(m_ptr + k) % N]) begin
            g  = (m_ptr + k) % N;
            ok = 1;
          end
        end
      end
    end
    if (ok) begin
      e.ready = N'(1) << g;
      e.wr    = 1'b1;
      e.id    = GW'(g);
      e.data  = bus.req_data[g*DW +: DW];
    end
    return e;
  endfunction

  task automatic model_commit(input exp_t e);
    if (!rst_n) return;
`ifdef ARB_BURST_EN
    if (m_burst) begin
      if (!bus.fifo_full) begin
        if (!e.wr) begin
          m_burst = 0;
        end else begin
          m_cnt++;
          if (m_cnt == BL || int'(bus.fifo_count) >= DEPTH - 1) m_burst = 0;
        end
      end
    end else if (e.wr && BL > 1 && int'(bus.fifo_count) < DEPTH - 1) begin
      m_burst = 1;
      m_lock  = int'(e.id);
      m_cnt   = 1;
    end
`endif
    if (e.wr) m_ptr = (int'(e.id) + 1) % N;
  endtask

  function automatic exp_t observed();
    return {bus.req_ready, bus.fifo_wr, bus.grant_id, bus.fifo_data};
  endfunction

  task automatic applyStimulus(input logic [N-1:0] v, input bit full, input int cnt);
    @(negedge clk);
    bus.req_valid  = v;
    bus.fifo_full  = full;
    bus.fifo_count = CW'(cnt);
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = DW'($urandom);
    #1;
  endtask

  task automatic applyReset();
    @(negedge clk);
    bus.req_valid = '0;
    rst_n = 1'b0;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    m_reset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus('1, 1'b0, 0);
      n_checks++;
      if (observed() !== '0) begin
        n_errors++;
        $display("[TB] FAIL reset_outputs cycle %0d: got %h, expected 0", i, observed());
      end
    end
    applyStimulus('1, 1'b0, 0);
    rst_n = 1'b1;
    #1;
    e = model_eval();
    n_checks++;
    if (bus.fifo_wr !== 1'b1 || bus.grant_id !== GW'(0)) begin
      n_errors++;
      $display("[TB] FAIL reset_first_grant: got wr=%b id=%0d, expected wr=1 id=0", bus.fifo_wr, bus.grant_id);
    end
    n_checks++;
    if (observed() !== e) begin
      n_errors++;
      $display("[TB] FAIL reset_first_model: got %h, expected %h", observed(), e);
    end
    model_commit(e);
  endtask

  task automatic test_round_robin();
    exp_t e;
    int   exp_ids [5] = '{0, 1, 2, 3, 0};
    applyReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus('1, 1'b0, 0);
      e = model_eval();
      n_checks++;
      if (observed() !== e) begin
        n_errors++;
        $display("[TB] FAIL rr_model cycle %0d: got %h, expected %h", i, observed(), e);
      end
`ifndef ARB_BURST_EN
      n_checks++;
      if (bus.grant_id !== GW'(exp_ids[i]) || bus.fifo_data !== bus.req_data[exp_ids[i]*DW +: DW]) begin
        n_errors++;
        $display("[TB] FAIL rr_order cycle %0d: got id=%0d data=%h, expected id=%0d", i, bus.grant_id, bus.fifo_data, exp_ids[i]);
      end
`endif
      model_commit(e);
    end
  endtask

  task automatic test_full_stall();
    exp_t e;
    bit   fulls   [7] = '{0, 0, 1, 1, 1, 0, 0};
    int   exp_ids [7] = '{0, 1, -1, -1, -1, 2, 3};
    applyReset();
    for (int i = 0; i < 7; i++) begin
      applyStimulus('1, fulls[i], fulls[i] ? DEPTH : 3);
      e = model_eval();
      n_checks++;
      if (observed() !== e) begin
        n_errors++;
        $display("[TB] FAIL stall_model cycle %0d: got %h, expected %h", i, observed(), e);
      end
`ifndef ARB_BURST_EN
      n_checks++;
      if (exp_ids[i] < 0 ? (bus.fifo_wr !== 1'b0 || bus.req_ready !== '0)
                         : (bus.fifo_wr !== 1'b1 || bus.grant_id !== GW'(exp_ids[i]))) begin
        n_errors++;
        $display("[TB] FAIL stall_order cycle %0d: got wr=%b id=%0d, expected id=%0d (-1 none)", i, bus.fifo_wr, bus.grant_id, exp_ids[i]);
      end
`endif
      model_commit(e);
    end
  endtask

  task automatic test_single_producer();
    exp_t e;
    applyReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus((i < 5) ? 4'b0100 : 4'b1111, 1'b0, 2);
      e = model_eval();
      n_checks++;
      if (observed() !== e) begin
        n_errors++;
        $display("[TB] FAIL single_model cycle %0d: got %h, expected %h", i, observed(), e);
      end
`ifndef ARB_BURST_EN
      n_checks++;
      if (bus.grant_id !== ((i < 5) ? GW'(2) : GW'(3))) begin
        n_errors++;
        $display("[TB] FAIL single_order cycle %0d: got id=%0d, expected %0d", i, bus.grant_id, (i < 5) ? 2 : 3);
      end
`endif
      model_commit(e);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    applyReset();
    for (int i = 0; i < 2; i++) begin
      applyStimulus('1, 1'b0, 0);
      e = model_eval();
      model_commit(e);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (observed() !== '0) begin
      n_errors++;
      $display("[TB] FAIL async_reset_outputs: got %h, expected 0", observed());
    end
    m_reset();
    applyStimulus('1, 1'b0, 0);
    rst_n = 1'b1;
    #1;
    e = model_eval();
    n_checks++;
    if (bus.grant_id !== GW'(0) || observed() !== e) begin
      n_errors++;
      $display("[TB] FAIL async_reset_regrant: got %h, expected %h", observed(), e);
    end
    model_commit(e);
  endtask

  task automatic test_random();
    exp_t e;
    int   bad;
    applyReset();
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      applyStimulus(N'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), $urandom_range(0, DEPTH));
      e = model_eval();
      n_checks++;
      if (observed() !== e) begin
        n_errors++;
        if (bad < 10) $display("[TB] FAIL random cycle %0d: got %h, expected %h", i, observed(), e);
        bad++;
      end
      model_commit(e);
    end
  endtask

`ifdef ARB_BURST_EN
  task automatic test_burst();
    exp_t e;
    applyReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(4'b0011, 1'b0, 0);
      e = model_eval();
      n_checks++;
      if (bus.grant_id !== GW'((i / BL) % 2) || observed() !== e) begin
        n_errors++;
        $display("[TB] FAIL burst_order cycle %0d: got %h, expected id=%0d model %h", i, observed(), (i / BL) % 2, e);
      end
      model_commit(e);
    end
  endtask

  task automatic test_burst_reset();
    exp_t e;
    applyReset();
    for (int i = 0; i < 2; i++) begin
      applyStimulus('1, 1'b0, 0);
      e = model_eval();
      n_checks++;
      if (bus.grant_id !== GW'(0) || observed() !== e) begin
        n_errors++;
        $display("[TB] FAIL burst_reset_beat %0d: got %h, expected %h", i, observed(), e);
      end
      model_commit(e);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (observed() !== '0) begin
      n_errors++;
      $display("[TB] FAIL burst_reset_outputs: got %h, expected 0", observed());
    end
    m_reset();
    applyStimulus(4'b0011, 1'b0, 0);
    rst_n = 1'b1;
    #1;
    e = model_eval();
    n_checks++;
    if (bus.grant_id !== GW'(0) || observed() !== e) begin
      n_errors++;
      $display("[TB] FAIL burst_reset_regrant: got %h, expected %h", observed(), e);
    end
    model_commit(e);
  endtask
`endif

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    rst_n          = 1'b0;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.fifo_full  = 1'b0;
    bus.fifo_count = '0;
    m_reset();
    test_reset();
    test_round_robin();
    test_full_stall();
    test_single_producer();
    test_async_reset();
`ifdef ARB_BURST_EN
    test_burst();
    test_burst_reset();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
